dmem_lsu: RTL and testbench
===========================

# dmem_lsu

Data-memory load/store unit sitting between the MEM stage of the RV32I pipeline and the data memory port. It accepts the stage's `data_mem_read`/`data_mem_write` request together with funct3, address and store value, and drives a word-aligned memory access with a byte write mask. It waits for the memory response and returns sign- or zero-extended load data. The pipeline is held with `stall` until the access completes.

## Interface
- TIMEOUT_CYCLES, 255: BUSY cycles without `dmem_resp` before the access is abandoned with `err`; 0 disables the timeout.

- clk  in  1  clock; everything samples on the rising edge
- rst  in  1  synchronous, active-high reset
- req_read  in  1  load request (control word `data_mem_read`)
- req_write  in  1  store request (control word `data_mem_write`)
- funct3  in  3  load_funct3_t / store_funct3_t encoding
- addr  in  32  byte address from the ALU
- store_data  in  32  rs2 value
- stall  out  1  combinational; holds the pipeline
- done  out  1  one-cycle completion pulse
- err  out  1  valid with `done`: misaligned, illegal funct3, or timeout
- load_data  out  32  extended load result; valid with `done`
- dmem_read  out  1  memory read strobe
- dmem_write  out  1  memory write strobe
- dmem_address  out  32  `{addr[31:2],2'b00}`
- dmem_wdata  out  32  lane-replicated store data
- dmem_wmask  out  4  byte enables
- dmem_rdata  in  32  memory read data
- dmem_resp  in  1  memory completion, one cycle

## Operation
- FSM states: IDLE, BUSY, DONE. Reset state is IDLE.
- In IDLE, a request is present when `req_read|req_write`. If both are high, the write wins and the read is ignored.
- Legality check on a request:
  - Loads: funct3 011, 110 and 111 are illegal.
  - Stores: funct3 above 010 is illegal.
  - lh, lhu and sh are misaligned when `addr[0]=1`.
  - lw and sw are misaligned when `addr[1:0]≠0`.
- Illegal or misaligned request: IDLE→DONE with `err=1` and `load_data=0`. No strobe is ever raised.
- Legal request: IDLE→BUSY. On the same edge the unit registers `dmem_address`, strobe, `dmem_wdata`, `dmem_wmask`, and latches funct3 and `addr[1:0]`.
- Store encoding:
  - sb: mask `4'b0001<<addr[1:0]`, wdata `{4{store_data[7:0]}}`.
  - sh: mask `4'b0011<<{addr[1],1'b0}`, wdata `{2{store_data[15:0]}}`.
  - sw: mask `4'b1111`, wdata `store_data`.
- Reads drive mask `4'b0000`.
- BUSY: the strobe and all `dmem_*` outputs are held stable until `dmem_resp` is sampled high. On that edge:
  - strobes drop to 0;
  - for a load, `load_data` is registered;
  - state goes to DONE.
- Load extraction:
  - lb/lbu: byte `dmem_rdata[8*a+:8]` with `a=addr[1:0]`, sign- or zero-extended.
  - lh/lhu: half `dmem_rdata[16*addr[1]+:16]`, sign- or zero-extended.
  - lw: whole word.
  - Stores return `load_data=0`.
- Timeout: a counter clears on BUSY entry and increments each BUSY cycle without resp. When it reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES≠0), the strobe drops and state goes to DONE with `err=1`, `load_data=0`. A resp arriving in that same cycle takes priority and gives a normal completion.
- DONE: `done=1` for exactly one cycle, then IDLE unconditionally. Requests are ignored in DONE, because the pipeline advances at the end of that cycle.
- `dmem_resp` seen in IDLE or DONE is ignored.

## Timing
- `stall = !rst && ((IDLE && request) || BUSY)`. It is low in DONE.
- Legal access, request first seen in cycle t:
  - strobe high from t+1;
  - earliest resp in t+1;
  - done in t+2, so `stall` is high in t and t+1.
  - Each extra memory wait cycle adds one cycle.
- Error request in cycle t: `stall` high in t only; `done`/`err` in t+1.
- Back-to-back: a new request may be accepted in the cycle after DONE. The minimum spacing between accesses is 3 cycles.
- Reset values: `dmem_read`, `dmem_write`, `dmem_wmask`, `dmem_address`, `dmem_wdata`, `load_data`, `done`, `err` are all 0, and the timeout counter is 0.
- Reset mid-BUSY: strobes are 0 after the reset edge, state is IDLE, and the in-flight result is discarded with no `done`. The first request after `rst` deasserts is handled normally.
- Outputs only change on clk edges, except `stall`.

## Test plan
- lw addr=0x1000, resp in t+1 with rdata=0xDEADBEEF -> `dmem_read` in t+1 at address 0x1000, `done` in t+2 with `load_data=0xDEADBEEF` and `err=0`; `stall` high in t and t+1 only.
- lb addr=0x1003 with rdata=0x80112233 -> `load_data=0xFFFFFF80`. lbu at the same address -> `0x00000080`. lhu addr=0x1002 -> `0x00008011`.
- sb addr=0x2001, store_data=0x000000AB -> mask `0010`, wdata `0xABABABAB`, address `0x2000`. sh addr=0x2002, data `0x1234` -> mask `1100`, wdata `0x12341234`.
- lw addr=0x1002 and sh addr=0x2001 -> no strobe is ever asserted; `done`+`err` one cycle after the request; `load_data=0`.
- TIMEOUT_CYCLES=4 with no resp -> strobe high for 4 cycles, then `err=1`. A late resp afterwards is ignored. Separately, resp on the 4th BUSY cycle gives a normal `done` with `err=0`.
- Reset asserted in the 2nd BUSY cycle, with req_read and req_write both high afterwards -> strobes cleared and no `done`; the next access is a write only (`dmem_write=1`, `dmem_read=0`).

Source files
------------

// File: rtl/dmem_lsu.sv
// dmem_lsu: MEM-stage load/store unit in front of a word-wide data memory.
// Steers store lanes, extends load data, checks alignment, bounds response wait.
module dmem_lsu #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_read,
  input  logic        req_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic        done,
  output logic        err,
  output logic [31:0] load_data,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [31:0] dmem_address,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam int CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST =
    (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

  state_t        state;
  state_t        state_nxt;
  logic          req;
  logic          bad;
  logic          tmo;
  logic [CW-1:0] cnt;
  logic [2:0]    f3_q;
  logic [1:0]    lane_q;
  logic          wr_q;
  logic [3:0]    mask_nxt;
  logic [31:0]   wdata_nxt;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;
  logic [31:0]   ext;

  assign req   = req_read | req_write;
  assign done  = (state == DONE);
  assign stall = !rst &&
    (((state == IDLE) && req) || (state == BUSY));

  assign tmo = (TIMEOUT_CYCLES != 0) && (cnt == LAST);

  // A write request wins, so legality is judged on store rules then.
  always_comb begin
    bad = 1'b0;
    if (req_write) begin
      unique case (1'b1)
        funct3 > 3'd2:     bad = 1'b1;
        funct3 == 3'b001:  bad = addr[0];
        funct3 == 3'b010:  bad = |addr[1:0];
        default:           bad = 1'b0;
      endcase
    end else begin
      unique case (1'b1)
        funct3 == 3'b011:      bad = 1'b1;
        funct3[2:1] == 2'b11:  bad = 1'b1;
        funct3[1:0] == 2'b01:  bad = addr[0];
        funct3 == 3'b010:      bad = |addr[1:0];
        default:               bad = 1'b0;
      endcase
    end
  end

  always_comb begin
    mask_nxt  = 4'b0000;
    wdata_nxt = 32'h0;
    if (req_write) begin
      unique case (funct3[1:0])
        2'b00: begin
          mask_nxt  = 4'b0001 << addr[1:0];
          wdata_nxt = {4{store_data[7:0]}};
        end
        2'b01: begin
          mask_nxt  = 4'b0011 << {addr[1], 1'b0};
          wdata_nxt = {2{store_data[15:0]}};
        end
        default: begin
          mask_nxt  = 4'b1111;
          wdata_nxt = store_data;
        end
      endcase
    end
  end

  always_comb begin
    rd_byte = dmem_rdata[{lane_q, 3'b000} +: 8];
    rd_half = dmem_rdata[{lane_q[1], 4'b0000} +: 16];
    ext     = dmem_rdata;
    unique case (f3_q)
      3'b000:  ext = {{24{rd_byte[7]}}, rd_byte};
      3'b100:  ext = {24'h0, rd_byte};
      3'b001:  ext = {{16{rd_half[15]}}, rd_half};
      3'b101:  ext = {16'h0, rd_half};
      default: ext = dmem_rdata;
    endcase
    if (wr_q) ext = 32'h0;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (req) state_nxt = bad ? DONE : BUSY;
      BUSY: if (dmem_resp || tmo) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dmem_read    <= 1'b0;
      dmem_write   <= 1'b0;
      dmem_address <= 32'h0;
      dmem_wdata   <= 32'h0;
      dmem_wmask   <= 4'b0000;
      load_data    <= 32'h0;
      err          <= 1'b0;
      cnt          <= '0;
      f3_q         <= 3'b000;
      lane_q       <= 2'b00;
      wr_q         <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req && bad) begin
            err       <= 1'b1;
            load_data <= 32'h0;
          end else if (req) begin
            dmem_address <= {addr[31:2], 2'b00};
            dmem_read    <= !req_write;
            dmem_write   <= req_write;
            dmem_wmask   <= mask_nxt;
            dmem_wdata   <= wdata_nxt;
            f3_q         <= funct3;
            lane_q       <= addr[1:0];
            wr_q         <= req_write;
            cnt          <= '0;
          end
        end
        BUSY: begin
          // A response in the timeout cycle still completes normally.
          if (dmem_resp) begin
            dmem_read  <= 1'b0;
            dmem_write <= 1'b0;
            load_data  <= ext;
            err        <= 1'b0;
          end else if (tmo) begin
            dmem_read  <= 1'b0;
            dmem_write <= 1'b0;
            load_data  <= 32'h0;
            err        <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: err <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu: directed and randomized checks of dmem_lsu against a
// byte-addressed memory model with a short response timeout.
module tb_dmem_lsu;

  logic        clk;
  logic        rst;
  logic        req_read;
  logic        req_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        stall;
  logic        done;
  logic        err;
  logic [31:0] load_data;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_address;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;

  int checks;
  int errors;

  int          o_lat;
  int          o_stall;
  int          o_strobes;
  logic        o_rd;
  logic        o_wr;
  logic        o_err;
  logic [31:0] o_addr;
  logic [31:0] o_wdata;
  logic [31:0] o_ld;
  logic [3:0]  o_mask;
  time         o_t0;

  logic [7:0]  mem_b [64];

  dmem_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk),
    .rst(rst),
    .req_read(req_read),
    .req_write(req_write),
    .funct3(funct3),
    .addr(addr),
    .store_data(store_data),
    .stall(stall),
    .done(done),
    .err(err),
    .load_data(load_data),
    .dmem_read(dmem_read),
    .dmem_write(dmem_write),
    .dmem_address(dmem_address),
    .dmem_wdata(dmem_wdata),
    .dmem_wmask(dmem_wmask),
    .dmem_rdata(dmem_rdata),
    .dmem_resp(dmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Presents one request in the cycle after the call and plays memory:
  // resp comes on BUSY cycle w+1. Records what the unit did.
  task automatic drive(input logic rd, input logic wr,
                       input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, input logic [31:0] rdata,
                       input int w);
    int b;
    o_lat = -1; o_stall = 0; o_strobes = 0;
    o_rd = 0; o_wr = 0; o_err = 0;
    o_addr = 0; o_wdata = 0; o_ld = 0; o_mask = 0;
    b = 0;
    @(posedge clk); #1;
    req_read = rd; req_write = wr; funct3 = f3;
    addr = a; store_data = sd;
    o_t0 = $time;
    #1;
    if (stall) o_stall++;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      dmem_resp = 1'b0;
      if (stall) o_stall++;
      if (done) begin
        o_lat = k; o_err = err; o_ld = load_data;
        break;
      end
      if (dmem_read | dmem_write) begin
        if (o_strobes == 0) begin
          o_rd = dmem_read; o_wr = dmem_write;
          o_addr = dmem_address; o_mask = dmem_wmask;
          o_wdata = dmem_wdata;
        end
        o_strobes++;
        b++;
        if (b == w + 1) begin
          dmem_resp = 1'b1;
          dmem_rdata = rdata;
        end
      end
    end
    req_read = 0; req_write = 0; dmem_resp = 0;
  endtask

  task automatic test_reset;
    rst = 1; req_read = 1; req_write = 0; funct3 = 0;
    addr = 0; store_data = 0; dmem_rdata = 0; dmem_resp = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({dmem_read, dmem_write, dmem_wmask, done, err, stall} !== 9'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 0",
        {dmem_read, dmem_write, dmem_wmask, done, err, stall});
    end
    checks++;
    if ({dmem_address, dmem_wdata, load_data} !== 96'h0) begin
      errors++;
      $display("FAIL reset_data got %h %h %h exp 0",
        dmem_address, dmem_wdata, load_data);
    end
    req_read = 0; rst = 0;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL idle_stall got %b exp 0", stall);
    end
  endtask

  task automatic test_loads;
    drive(1, 0, 3'b010, 32'h1000, 0, 32'hDEADBEEF, 0);
    checks++;
    if ({o_rd, o_wr, o_mask, o_addr} !== {2'b10, 4'b0, 32'h1000}) begin
      errors++;
      $display("FAIL lw_port got %b%b %b %h exp 10 0000 00001000",
        o_rd, o_wr, o_mask, o_addr);
    end
    checks++;
    if (o_lat !== 2 || o_stall !== 2 || o_err !== 1'b0) begin
      errors++;
      $display("FAIL lw_timing got lat %0d stall %0d err %b exp 2 2 0",
        o_lat, o_stall, o_err);
    end
    checks++;
    if (o_ld !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL lw_data got %h exp deadbeef", o_ld);
    end
    drive(1, 0, 3'b000, 32'h1003, 0, 32'h80112233, 1);
    checks++;
    if (o_ld !== 32'hFFFFFF80 || o_lat !== 3) begin
      errors++;
      $display("FAIL lb got %h lat %0d exp ffffff80 3", o_ld, o_lat);
    end
    drive(1, 0, 3'b100, 32'h1003, 0, 32'h80112233, 0);
    checks++;
    if (o_ld !== 32'h00000080) begin
      errors++;
      $display("FAIL lbu got %h exp 00000080", o_ld);
    end
    drive(1, 0, 3'b101, 32'h1002, 0, 32'h80112233, 0);
    checks++;
    if (o_ld !== 32'h00008011) begin
      errors++;
      $display("FAIL lhu got %h exp 00008011", o_ld);
    end
  endtask

  task automatic test_stores;
    drive(0, 1, 3'b000, 32'h2001, 32'h000000AB, 0, 0);
    checks++;
    if ({o_wr, o_rd, o_mask, o_addr, o_wdata} !==
        {2'b10, 4'b0010, 32'h2000, 32'hABABABAB}) begin
      errors++;
      $display("FAIL sb got wr %b rd %b m %b a %h d %h",
        o_wr, o_rd, o_mask, o_addr, o_wdata);
    end
    checks++;
    if (o_ld !== 32'h0 || o_err !== 1'b0 || o_lat !== 2) begin
      errors++;
      $display("FAIL sb_done got ld %h err %b lat %0d exp 0 0 2",
        o_ld, o_err, o_lat);
    end
    drive(0, 1, 3'b001, 32'h2002, 32'h00001234, 0, 0);
    checks++;
    if ({o_mask, o_addr, o_wdata} !==
        {4'b1100, 32'h2000, 32'h12341234}) begin
      errors++;
      $display("FAIL sh got m %b a %h d %h exp 1100 2000 12341234",
        o_mask, o_addr, o_wdata);
    end
  endtask

  task automatic test_misaligned;
    drive(1, 0, 3'b010, 32'h1002, 0, 32'hFFFFFFFF, 0);
    checks++;
    if (o_strobes !== 0 || o_lat !== 1 || o_err !== 1'b1 ||
        o_ld !== 0 || o_stall !== 1) begin
      errors++;
      $display("FAIL lw_mis got st %0d lat %0d err %b ld %h stall %0d",
        o_strobes, o_lat, o_err, o_ld, o_stall);
    end
    drive(0, 1, 3'b001, 32'h2001, 32'h5555, 0, 0);
    checks++;
    if (o_strobes !== 0 || o_lat !== 1 || o_err !== 1'b1 ||
        o_ld !== 0) begin
      errors++;
      $display("FAIL sh_mis got st %0d lat %0d err %b ld %h",
        o_strobes, o_lat, o_err, o_ld);
    end
    drive(1, 0, 3'b011, 32'h1000, 0, 0, 0);
    checks++;
    if (o_strobes !== 0 || o_err !== 1'b1 || o_lat !== 1) begin
      errors++;
      $display("FAIL ld_f3 got st %0d err %b lat %0d exp 0 1 1",
        o_strobes, o_err, o_lat);
    end
  endtask

  task automatic test_timeout;
    drive(1, 0, 3'b010, 32'h1000, 0, 32'h12345678, 100);
    checks++;
    if (o_strobes !== 4 || o_lat !== 5 || o_err !== 1'b1 ||
        o_ld !== 0) begin
      errors++;
      $display("FAIL tmo got st %0d lat %0d err %b ld %h exp 4 5 1 0",
        o_strobes, o_lat, o_err, o_ld);
    end
    @(posedge clk); #1;
    dmem_resp = 1'b1;
    @(posedge clk); #1;
    dmem_resp = 1'b0;
    checks++;
    if ({done, err, dmem_read, stall} !== 4'b0) begin
      errors++;
      $display("FAIL late_resp got %b exp 0000",
        {done, err, dmem_read, stall});
    end
    drive(1, 0, 3'b010, 32'h1000, 0, 32'h12345678, 3);
    checks++;
    if (o_lat !== 5 || o_err !== 1'b0 || o_ld !== 32'h12345678) begin
      errors++;
      $display("FAIL tmo_edge got lat %0d err %b ld %h exp 5 0 12345678",
        o_lat, o_err, o_ld);
    end
  endtask

  task automatic test_reset_busy;
    int seen;
    @(posedge clk); #1;
    req_read = 1; funct3 = 3'b010; addr = 32'h1000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1; req_write = 1; addr = 32'h2004; store_data = 32'hCAFEF00D;
    @(posedge clk); #1;
    checks++;
    if ({dmem_read, dmem_write, done, stall} !== 4'b0 ||
        dmem_address !== 32'h0) begin
      errors++;
      $display("FAIL rst_busy got %b a %h exp 0000 0",
        {dmem_read, dmem_write, done, stall}, dmem_address);
    end
    rst = 0;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL rst_req_stall got %b exp 1", stall);
    end
    @(posedge clk); #1;
    checks++;
    if ({dmem_write, dmem_read, done} !== 3'b100 ||
        dmem_address !== 32'h2004 || dmem_wdata !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL rst_next got %b a %h d %h exp 100 2004 cafef00d",
        {dmem_write, dmem_read, done}, dmem_address, dmem_wdata);
    end
    dmem_resp = 1;
    @(posedge clk); #1;
    dmem_resp = 0; req_read = 0; req_write = 0;
    seen = done;
    checks++;
    if (seen !== 1 || err !== 1'b0) begin
      errors++;
      $display("FAIL rst_next_done got %0d err %b exp 1 0", seen, err);
    end
  endtask

  task automatic test_back_to_back;
    time t1;
    drive(1, 0, 3'b010, 32'h1004, 0, 32'h0BADF00D, 0);
    t1 = o_t0;
    drive(0, 1, 3'b010, 32'h1008, 32'h11112222, 0, 0);
    checks++;
    if (o_t0 - t1 !== 30 || o_lat !== 2 || o_stall !== 2 ||
        o_wr !== 1'b1) begin
      errors++;
      $display("FAIL b2b got gap %0t lat %0d stall %0d wr %b exp 30 2 2 1",
        o_t0 - t1, o_lat, o_stall, o_wr);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse got %b exp 0", done);
    end
  endtask

  task automatic test_random;
    logic        rd, wr, sgn, legal;
    logic [2:0]  f3;
    logic [31:0] a, sd, rw, v, ew;
    logic [3:0]  em;
    int          off, sz, w, base, el;
    for (int i = 0; i < 64; i++) mem_b[i] = 8'($urandom);
    for (int i = 0; i < 150; i++) begin
      wr  = 1'($urandom);
      rd  = wr ? 1'($urandom) : 1'b1;
      f3  = 3'($urandom_range(0, 7));
      off = $urandom_range(0, 63);
      a   = 32'h3000 + off;
      sd  = $urandom;
      w   = $urandom_range(0, 2);
      sz  = 1 << f3[1:0];
      sgn = !f3[2];
      base = off & ~3;
      rw  = {mem_b[base+3], mem_b[base+2], mem_b[base+1], mem_b[base]};
      legal = wr ? (f3 <= 3'd2) : (f3 != 3 && f3 != 6 && f3 != 7);
      if (legal && (off % sz) != 0) legal = 0;
      v = 0; ew = 0; em = 0;
      if (legal && wr) begin
        em = 4'(((1 << sz) - 1) << (off % 4));
        if (sz == 1) ew = {24'h0, sd[7:0]} * 32'h01010101;
        else if (sz == 2) ew = {16'h0, sd[15:0]} * 32'h00010001;
        else ew = sd;
        for (int j = 0; j < sz; j++) mem_b[off+j] = sd[8*j +: 8];
      end else if (legal) begin
        for (int j = 0; j < sz; j++) v |= 32'(mem_b[off+j]) << (8*j);
        if (sgn && sz < 4 && v[8*sz-1]) v |= ~((32'd1 << (8*sz)) - 1);
      end
      drive(rd, wr, f3, a, sd, rw, w);
      el = legal ? w + 2 : 1;
      checks++;
      if (o_lat !== el || o_err !== !legal || o_stall !== el) begin
        errors++;
        $display("FAIL rnd%0d_ctl got lat %0d err %b stall %0d exp %0d %b",
          i, o_lat, o_err, o_stall, el, !legal);
      end
      checks++;
      if (o_ld !== v) begin
        errors++;
        $display("FAIL rnd%0d_ld f3 %0d a %h got %h exp %h",
          i, f3, a, o_ld, v);
      end
      checks++;
      if (o_strobes !== (legal ? w + 1 : 0)) begin
        errors++;
        $display("FAIL rnd%0d_strobes got %0d", i, o_strobes);
      end
      if (legal) begin
        checks++;
        if ({o_rd, o_wr, o_mask, o_addr, o_wdata & {32{wr}}} !==
            {!wr, wr, em, a & ~32'd3, ew}) begin
          errors++;
          $display("FAIL rnd%0d_port got %b%b %b %h %h exp %b%b %b %h %h",
            i, o_rd, o_wr, o_mask, o_addr, o_wdata,
            !wr, wr, em, a & ~32'd3, ew);
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_loads();
    test_stores();
    test_misaligned();
    test_timeout();
    test_reset_busy();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
